// File: rtl/sevenseg_scan_driver.sv
// Binary to multi-digit seven-segment driver: a sequential double-dabble conversion
// feeds atomically updated display registers that are time-multiplexed onto common-anode digits.
module sevenseg_scan_driver #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              signed_en,
  input  logic              load,
  output logic              ready,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [1:0]        fsm_state
);

  localparam int BW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;

  // S_IDLE is encoded as 0 so fsm_state reads 0 whenever ready is high.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    mag_q;
  logic [WIDTH-1:0]    mag_in;
  logic [BW-1:0]       bcd_q;
  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic                neg_q;
  logic                neg_in;
  logic [CW-1:0]       step_q;

  logic [6:0]          disp_q [DIGITS];
  logic [6:0]          disp_d [DIGITS];
  logic                ovf_q;
  logic                ovf_d;
  int                  ndig;

  logic [RW-1:0]       ref_q;
  logic [IW-1:0]       idx_q;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Handshake: load is taken on a rising edge only while ready=1; a load seen
  // while ready=0 is dropped, never queued. ready falls on the accepting edge.
  assign ready     = (state_q == S_IDLE);
  assign overflow  = ovf_q;
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load) state_d = S_CONVERT;
      S_CONVERT: if (step_q == STEP_LAST) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  assign neg_in = signed_en & value[WIDTH-1];
  assign mag_in = neg_in ? (~value + WIDTH'(1)) : value;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, mag_q} << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_q  <= '0;
      bcd_q  <= '0;
      neg_q  <= 1'b0;
      step_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            mag_q  <= mag_in;
            neg_q  <= neg_in;
            bcd_q  <= '0;
            step_q <= '0;
          end
        end
        S_CONVERT: begin
          {bcd_q, mag_q} <= shifted;
          step_q         <= step_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // ndig = number of significant digits (at least 1, so zero shows "0").
  always_comb begin
    ndig = 1;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ndig = i + 1;
    end
    ovf_d = (bcd_q[4*DIGITS +: 4] != 4'd0) || (neg_q && (ndig == DIGITS));
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_d)                    disp_d[i] = SEG_MINUS;
      else if (i < ndig)            disp_d[i] = glyph(bcd_q[4*i +: 4]);
      else if (neg_q && i == ndig)  disp_d[i] = SEG_MINUS;
      else                          disp_d[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
      ovf_q <= 1'b0;
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= disp_d[i];
      ovf_q <= ovf_d;
    end
  end

  // Scan runs free of the FSM; seg and an are registered together so they stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q <= '0;
      idx_q <= '0;
      an    <= '1;
      seg   <= SEG_BLANK;
    end else begin
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        ref_q <= ref_q + RW'(1);
      end
      an  <= ~(DIGITS'(1) << idx_q);
      seg <= disp_q[idx_q];
    end
  end

endmodule
